reg_dump_sequencer: RTL and testbench



---
 rtl/reg_dump_sequencer_pkg.sv | 19 +
 rtl/word_byte_serializer.sv | 57 +++++
 rtl/reg_dump_sequencer.sv | 106 ++++++++++
 tb/tb_reg_dump_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_sequencer_pkg.sv
// Shared definitions for the debug register dump path.
// Used by the dump FSM, its byte serializer and the debug unit.
package reg_dump_sequencer_pkg;

  localparam int NUM_REGS        = 32;
  localparam int DATA_WIDTH      = 32;
  localparam int BYTES_PER_WORD  = DATA_WIDTH / 8;
  localparam int DUMP_BYTE_COUNT = NUM_REGS * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Splits a loaded word into bytes, MSB first, over valid/ready.
// o_last pulses in the cycle the final byte is accepted.
module word_byte_serializer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_last
);

  localparam int BPW = DATA_WIDTH / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_n;
  logic [CW-1:0]         cnt_q;
  logic [7:0]            data_q;
  logic                  valid_q;
  logic                  xfer;
  logic                  last_byte;

  assign shift_n   = shift_q << 8;
  assign xfer      = valid_q && i_tx_ready;
  assign last_byte = (cnt_q == CW'(BPW - 1));
  assign o_last    = xfer && last_byte;

  assign o_tx_data  = data_q;
  assign o_tx_valid = valid_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      shift_q <= i_word;
      cnt_q   <= '0;
      data_q  <= i_word[DATA_WIDTH-1 -: 8];
      valid_q <= 1'b1;
    end else if (xfer) begin
      if (last_byte) begin
        valid_q <= 1'b0;
      end else begin
        shift_q <= shift_n;
        cnt_q   <= cnt_q + 1'b1;
        data_q  <= shift_n[DATA_WIDTH-1 -: 8];
      end
    end
  end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Halts the pipeline and streams all GPRs out as bytes
// through the debug UART, MSB first per register.
module reg_dump_sequencer #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  output logic                  o_halt,
  output logic [ADDR_WIDTH-1:0] o_reg_read,
  input  logic [DATA_WIDTH-1:0] i_reg_content,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  import reg_dump_sequencer_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_REG =
    ADDR_WIDTH'(NUM_REGS - 1);

  dump_state_e           state_q;
  dump_state_e           state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  final_q;
  logic                  final_d;
  logic                  halt_q;
  logic                  done_q;
  logic                  load;
  logic                  ser_last;

  word_byte_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (load),
    .i_word     (i_reg_content),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_last     (ser_last)
  );

  // The address advances on the last-byte edge, so NEXT doubles
  // as the read-mux settle cycle for the following register.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    final_d = final_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ADDR;
          addr_d  = '0;
          final_d = 1'b0;
        end
      end
      ST_ADDR: state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (ser_last) begin
          state_d = ST_NEXT;
          final_d = (addr_q == LAST_REG);
          if (addr_q != LAST_REG) begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_NEXT: state_d = final_q ? ST_DONE : ST_LOAD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      final_q <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      final_q <= final_d;
      halt_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign o_halt     = halt_q;
  assign o_busy     = halt_q;
  assign o_done     = done_q;
  assign o_reg_read = addr_q;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Directed bench for reg_dump_sequencer: timing, stream
// content, backpressure, ignored starts and mid-dump reset.
module tb_reg_dump_sequencer;
  import reg_dump_sequencer_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        i_start = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic        o_halt;
  logic [4:0]  o_reg_read;
  logic [31:0] i_reg_content;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;

  reg_dump_sequencer dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_start       (i_start),
    .o_halt        (o_halt),
    .o_reg_read    (o_reg_read),
    .i_reg_content (i_reg_content),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  bit bp_mode = 1'b0;
  bit start_on_done = 1'b0;

  logic [7:0] byte_q[$];
  int  k, done_cnt, done_k, done_addr;
  int  halt_cnt, halt_first, busy_cnt, valid_cnt;
  int  addr_err, stall_err;
  bit  prev_stall;
  logic [7:0] prev_data;

  function automatic logic [31:0] bank(input logic [4:0] a,
                                       input bit bpm);
    logic [31:0] w;
    w = 32'h0100_0000 * a + 32'h00A5_A5A5 + 32'(a);
    if (bpm && a == 5'd5) w = 32'hDEAD_BEEF;
    return w;
  endfunction

  always_comb begin
    i_reg_content = 32'h0100_0000 * o_reg_read
                  + 32'h00A5_A5A5 + 32'(o_reg_read);
    if (bp_mode && o_reg_read == 5'd5)
      i_reg_content = 32'hDEAD_BEEF;
  end

  function automatic int first_diff(input bit bpm);
    logic [31:0] w;
    if (byte_q.size() != DUMP_BYTE_COUNT) return -2;
    for (int i = 0; i < DUMP_BYTE_COUNT; i++) begin
      w = bank(5'(i / 4), bpm);
      if (byte_q[i] !== w[31 - 8 * (i % 4) -: 8]) return i;
    end
    return -1;
  endfunction

  task automatic clear_stats();
    byte_q.delete();
    k = -1; done_cnt = 0; done_k = -1; done_addr = -1;
    halt_cnt = 0; halt_first = -1; busy_cnt = 0;
    valid_cnt = 0; addr_err = 0; stall_err = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
  endtask

  task automatic cyc(input bit rnd, input bit st);
    @(posedge i_clk); #1;
    k++;
    if (prev_stall &&
        (o_tx_valid !== 1'b1 || o_tx_data !== prev_data))
      stall_err++;
    if (o_tx_valid && o_reg_read !== 5'(byte_q.size() / 4))
      addr_err++;
    if (o_halt) begin
      halt_cnt++;
      if (halt_first < 0) halt_first = k;
    end
    if (o_busy) busy_cnt++;
    if (o_tx_valid) valid_cnt++;
    if (o_done) begin
      done_cnt++; done_k = k; done_addr = int'(o_reg_read);
    end
    i_start = st || (start_on_done && o_done);
    i_tx_ready = rnd ? 1'($urandom_range(0, 9) < 3) : 1'b1;
    if (o_tx_valid && i_tx_ready) byte_q.push_back(o_tx_data);
    prev_stall = o_tx_valid && !i_tx_ready;
    prev_data = o_tx_data;
  endtask

  task automatic start_dump();
    @(posedge i_clk); #1;
    i_start = 1'b1;
    clear_stats();
  endtask

  task automatic run_idle(input bit rnd, input int budget,
                          output bit ok);
    do cyc(rnd, 1'b0); while (o_busy && k < budget);
    ok = !o_busy;
  endtask

  task automatic test_reset();
    #3 i_reset_n = 1'b0;
    #1;
    total++;
    if ({o_halt, o_reg_read, o_tx_data, o_tx_valid,
         o_busy, o_done} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 0",
        {o_halt, o_reg_read, o_tx_data, o_tx_valid,
         o_busy, o_done});
    end
    @(posedge i_clk); #2 i_reset_n = 1'b1;
    clear_stats();
    repeat (20) cyc(1'b0, 1'b0);
    total++;
    if (halt_cnt + busy_cnt + valid_cnt != 0) begin
      bad++;
      $display("FAIL idle_quiet: halt=%0d busy=%0d valid=%0d want 0",
        halt_cnt, busy_cnt, valid_cnt);
    end
  endtask

  task automatic test_full_dump();
    bit ok;
    int d;
    start_dump();
    run_idle(1'b0, 400, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL full_timeout: busy=%b want 0", o_busy);
    end
    total++;
    if (byte_q.size() != 128) begin
      bad++;
      $display("FAIL full_count: got %0d want 128", byte_q.size());
    end
    total++;
    if ({byte_q[0], byte_q[1], byte_q[2], byte_q[3]}
        !== 32'h00A5_A5A5) begin
      bad++;
      $display("FAIL full_first: got %h%h%h%h want 00a5a5a5",
        byte_q[0], byte_q[1], byte_q[2], byte_q[3]);
    end
    total++;
    if ({byte_q[124], byte_q[125], byte_q[126], byte_q[127]}
        !== 32'h1FA5_A5C4) begin
      bad++;
      $display("FAIL full_last: got %h%h%h%h want 1fa5a5c4",
        byte_q[124], byte_q[125], byte_q[126], byte_q[127]);
    end
    d = first_diff(1'b0);
    total++;
    if (d != -1) begin
      bad++; $display("FAIL full_stream: first bad index %0d want -1", d);
    end
    total++;
    if (done_cnt != 1 || done_k != 193) begin
      bad++;
      $display("FAIL full_done: pulses=%0d at=%0d want 1 at 193",
        done_cnt, done_k);
    end
    total++;
    if (halt_first != 0 || halt_cnt != 194) begin
      bad++;
      $display("FAIL full_halt: first=%0d cycles=%0d want 0/194",
        halt_first, halt_cnt);
    end
    total++;
    if (addr_err != 0 || done_addr != 31) begin
      bad++;
      $display("FAIL full_addr: errs=%0d done_addr=%0d want 0/31",
        addr_err, done_addr);
    end
    total++;
    if (k != 194 || o_halt !== 1'b0) begin
      bad++;
      $display("FAIL full_idle: at=%0d halt=%b want 194/0", k, o_halt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int d;
    bp_mode = 1'b1;
    start_dump();
    run_idle(1'b1, 3000, ok);
    total++;
    if (!ok) begin
      bad++; $display("FAIL bp_timeout: busy=%b want 0", o_busy);
    end
    total++;
    if ({byte_q[20], byte_q[21], byte_q[22], byte_q[23]}
        !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL bp_reg5: got %h%h%h%h want deadbeef",
        byte_q[20], byte_q[21], byte_q[22], byte_q[23]);
    end
    d = first_diff(1'b1);
    total++;
    if (d != -1) begin
      bad++;
      $display("FAIL bp_stream: first bad index %0d (n=%0d) want -1",
        d, byte_q.size());
    end
    total++;
    if (stall_err != 0 || addr_err != 0 || done_cnt != 1) begin
      bad++;
      $display("FAIL bp_hold: stall=%0d addr=%0d done=%0d want 0/0/1",
        stall_err, addr_err, done_cnt);
    end
    bp_mode = 1'b0;
  endtask

  task automatic test_ignored_start();
    bit s10 = 1'b0;
    bit s64 = 1'b0;
    bit st;
    bit ok;
    int d;
    start_dump();
    start_on_done = 1'b1;
    do begin
      st = 1'b0;
      if (!s10 && byte_q.size() == 10) begin st = 1'b1; s10 = 1'b1; end
      if (!s64 && byte_q.size() == 64) begin st = 1'b1; s64 = 1'b1; end
      cyc(1'b0, st);
    end while (o_busy && k < 400);
    start_on_done = 1'b0;
    repeat (6) cyc(1'b0, 1'b0);
    total++;
    if (byte_q.size() != 128 || done_cnt != 1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL ign_once: bytes=%0d done=%0d busy=%b want 128/1/0",
        byte_q.size(), done_cnt, o_busy);
    end
    start_dump();
    run_idle(1'b0, 400, ok);
    d = first_diff(1'b0);
    total++;
    if (!ok || d != -1 || done_cnt != 1) begin
      bad++;
      $display("FAIL ign_redump: ok=%b diff=%0d done=%0d want 1/-1/1",
        ok, d, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    start_dump();
    do cyc(1'b0, 1'b0); while (byte_q.size() < 50 && k < 400);
    total++;
    if (o_reg_read !== 5'd12 || o_tx_valid !== 1'b1 ||
        o_tx_data !== 8'hA5) begin
      bad++;
      $display("FAIL mid_pos: reg=%0d v=%b d=%h want 12/1/a5",
        o_reg_read, o_tx_valid, o_tx_data);
    end
    #2 i_reset_n = 1'b0;
    #1;
    total++;
    if ({o_tx_valid, o_halt, o_busy, o_done} !== 4'b0 ||
        o_reg_read !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset: v=%b h=%b b=%b d=%b r=%0d want 0",
        o_tx_valid, o_halt, o_busy, o_done, o_reg_read);
    end
    @(posedge i_clk); #2 i_reset_n = 1'b1;
    clear_stats();
    repeat (5) cyc(1'b0, 1'b0);
    total++;
    if (byte_q.size() != 0 || busy_cnt != 0) begin
      bad++;
      $display("FAIL mid_quiet: bytes=%0d busy=%0d want 0/0",
        byte_q.size(), busy_cnt);
    end
    start_dump();
    run_idle(1'b0, 400, ok);
    d = first_diff(1'b0);
    total++;
    if (!ok || d != -1 || done_cnt != 1) begin
      bad++;
      $display("FAIL mid_redump: ok=%b diff=%0d done=%0d want 1/-1/1",
        ok, d, done_cnt);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
